// File: rtl/spu_writeback_pipe_if.sv
// rtl/spu_writeback_pipe_if.sv - issue, register-file write and forwarding bus of the writeback pipe
interface spu_writeback_pipe_if #(
  parameter int LAT_W  = 3,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
);
  logic              flush;

  logic              res_valid_even;
  logic [ADDR_W-1:0] res_addr_even;
  logic [DATA_W-1:0] res_data_even;
  logic [LAT_W-1:0]  res_lat_even;
  logic              res_valid_odd;
  logic [ADDR_W-1:0] res_addr_odd;
  logic [DATA_W-1:0] res_data_odd;
  logic [LAT_W-1:0]  res_lat_odd;

  logic [ADDR_W-1:0] rt_addr_even;
  logic [DATA_W-1:0] rt_even;
  logic              reg_write_even;
  logic [ADDR_W-1:0] rt_addr_odd;
  logic [DATA_W-1:0] rt_odd;
  logic              reg_write_odd;

  logic [ADDR_W-1:0] q_addr_a;
  logic [ADDR_W-1:0] q_addr_b;
  logic [ADDR_W-1:0] q_addr_c;
  logic              fwd_hit_a;
  logic              fwd_hit_b;
  logic              fwd_hit_c;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
  logic [DATA_W-1:0] fwd_data_c;

  logic              slot_conflict_even;
  logic              slot_conflict_odd;
  logic              waw_drop;

  modport master (
    output flush,
    output res_valid_even, res_addr_even, res_data_even, res_lat_even,
    output res_valid_odd, res_addr_odd, res_data_odd, res_lat_odd,
    input  rt_addr_even, rt_even, reg_write_even,
    input  rt_addr_odd, rt_odd, reg_write_odd,
    output q_addr_a, q_addr_b, q_addr_c,
    input  fwd_hit_a, fwd_hit_b, fwd_hit_c,
    input  fwd_data_a, fwd_data_b, fwd_data_c,
    input  slot_conflict_even, slot_conflict_odd, waw_drop
  );

  modport slave (
    input  flush,
    input  res_valid_even, res_addr_even, res_data_even, res_lat_even,
    input  res_valid_odd, res_addr_odd, res_data_odd, res_lat_odd,
    output rt_addr_even, rt_even, reg_write_even,
    output rt_addr_odd, rt_odd, reg_write_odd,
    input  q_addr_a, q_addr_b, q_addr_c,
    output fwd_hit_a, fwd_hit_b, fwd_hit_c,
    output fwd_data_a, fwd_data_b, fwd_data_c,
    output slot_conflict_even, slot_conflict_odd, waw_drop
  );
endinterface

// File: rtl/spu_writeback_pipe.sv
// rtl/spu_writeback_pipe.sv - latency-tagged writeback staging for even/odd pipes with RF write and forwarding
module spu_writeback_pipe #(
  parameter int DEPTH  = 7,
  parameter int LAT_W  = 3,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                reset,
  spu_writeback_pipe_if.slave wb
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Index 0 is the even pipe, index 1 the odd pipe throughout.
  logic              in_v [2];
  logic [ADDR_W-1:0] in_a [2];
  logic [DATA_W-1:0] in_d [2];
  logic [LAT_W-1:0]  in_l [2];

  logic              slot_v [2][DEPTH];
  logic [ADDR_W-1:0] slot_a [2][DEPTH];
  logic [DATA_W-1:0] slot_d [2][DEPTH];

  logic              nxt_v  [2][DEPTH];
  logic [ADDR_W-1:0] nxt_a  [2][DEPTH];
  logic [DATA_W-1:0] nxt_d  [2][DEPTH];
  logic [IDX_W-1:0]  tgt    [2];
  logic              conf_nxt [2];

  logic              out_v     [2];
  logic [ADDR_W-1:0] out_a     [2];
  logic [DATA_W-1:0] out_d     [2];
  logic              out_v_nxt [2];
  logic              conf_q    [2];
  logic              waw_nxt;
  logic              waw_q;

  logic [ADDR_W-1:0] q_addr [3];
  logic              q_hit  [3];
  logic [DATA_W-1:0] q_data [3];

  assign in_v[0] = wb.res_valid_even;
  assign in_a[0] = wb.res_addr_even;
  assign in_d[0] = wb.res_data_even;
  assign in_l[0] = wb.res_lat_even;
  assign in_v[1] = wb.res_valid_odd;
  assign in_a[1] = wb.res_addr_odd;
  assign in_d[1] = wb.res_data_odd;
  assign in_l[1] = wb.res_lat_odd;

  // Latency L lands in slot L-1; 0 behaves as 1 and anything beyond DEPTH saturates.
  function automatic logic [IDX_W-1:0] lat_to_slot(input logic [LAT_W-1:0] lat);
    logic [IDX_W-1:0] s;
    if (lat == '0) begin
      s = '0;
    end else if (int'(lat) > DEPTH) begin
      s = IDX_W'(DEPTH - 1);
    end else begin
      s = IDX_W'(int'(lat) - 1);
    end
    return s;
  endfunction

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        nxt_v[p][k] = slot_v[p][k+1];
        nxt_a[p][k] = slot_a[p][k+1];
        nxt_d[p][k] = slot_d[p][k+1];
      end
      nxt_v[p][DEPTH-1] = 1'b0;
      nxt_a[p][DEPTH-1] = '0;
      nxt_d[p][DEPTH-1] = '0;
      tgt[p]            = lat_to_slot(in_l[p]);
      conf_nxt[p]       = 1'b0;
      // A newer issue overwrites whatever older result shifted into its slot.
      if (in_v[p]) begin
        conf_nxt[p]          = nxt_v[p][tgt[p]];
        nxt_v[p][tgt[p]]     = 1'b1;
        nxt_a[p][tgt[p]]     = in_a[p];
        nxt_d[p][tgt[p]]     = in_d[p];
      end
    end
  end

  // Same-address writes reaching the outputs together: the odd pipe wins.
  always_comb begin
    waw_nxt      = slot_v[0][0] && slot_v[1][0] && (slot_a[0][0] == slot_a[1][0]);
    out_v_nxt[0] = slot_v[0][0] && !waw_nxt;
    out_v_nxt[1] = slot_v[1][0];
  end

  always_ff @(posedge clk) begin
    if (reset || wb.flush) begin
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < DEPTH; k++) begin
          slot_v[p][k] <= 1'b0;
        end
        out_v[p]  <= 1'b0;
        out_a[p]  <= '0;
        out_d[p]  <= '0;
        conf_q[p] <= 1'b0;
      end
      waw_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < DEPTH; k++) begin
          slot_v[p][k] <= nxt_v[p][k];
        end
        out_v[p]  <= out_v_nxt[p];
        out_a[p]  <= out_v_nxt[p] ? slot_a[p][0] : '0;
        out_d[p]  <= out_v_nxt[p] ? slot_d[p][0] : '0;
        conf_q[p] <= conf_nxt[p];
      end
      waw_q <= waw_nxt;
    end
  end

  // Payload is only meaningful under its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_a[p][k] <= nxt_a[p][k];
        slot_d[p][k] <= nxt_d[p][k];
      end
    end
  end

  assign q_addr[0] = wb.q_addr_a;
  assign q_addr[1] = wb.q_addr_b;
  assign q_addr[2] = wb.q_addr_c;

  // Later matches override earlier ones: outputs, then slots by rising index, even before odd.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      q_hit[i]  = 1'b0;
      q_data[i] = '0;
      for (int p = 0; p < 2; p++) begin
        if (out_v[p] && (out_a[p] == q_addr[i])) begin
          q_hit[i]  = 1'b1;
          q_data[i] = out_d[p];
        end
      end
      for (int k = 0; k < DEPTH; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (slot_v[p][k] && (slot_a[p][k] == q_addr[i])) begin
            q_hit[i]  = 1'b1;
            q_data[i] = slot_d[p][k];
          end
        end
      end
    end
  end

  assign wb.reg_write_even     = out_v[0];
  assign wb.rt_addr_even       = out_a[0];
  assign wb.rt_even            = out_d[0];
  assign wb.reg_write_odd      = out_v[1];
  assign wb.rt_addr_odd        = out_a[1];
  assign wb.rt_odd             = out_d[1];
  assign wb.slot_conflict_even = conf_q[0];
  assign wb.slot_conflict_odd  = conf_q[1];
  assign wb.waw_drop           = waw_q;

  assign wb.fwd_hit_a  = q_hit[0];
  assign wb.fwd_hit_b  = q_hit[1];
  assign wb.fwd_hit_c  = q_hit[2];
  assign wb.fwd_data_a = q_data[0];
  assign wb.fwd_data_b = q_data[1];
  assign wb.fwd_data_c = q_data[2];

endmodule

// File: doc/spu_writeback_pipe.md
Name: spu_writeback_pipe

Overview:
- Producer side of the register-file write interface.
- Accepts finished results from the even and odd execution pipes, each tagged with a writeback latency.
- Holds each result in a per-pipe staging shift register, then drives rt_addr_even/rt_even/reg_write_even and rt_addr_odd/rt_odd/reg_write_odd into RegisterTable on the correct cycle.
- Provides three forwarding lookups so operand fetch sees in-flight values.

Parameters:
- DEPTH, 7: staging slots per pipe; maximum writeback latency.
- LAT_W, 3: width of the latency tag.
- ADDR_W, 7: register address width.
- DATA_W, 128: register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all in-flight results.
- res_valid_even  in  1  even result issued this cycle.
- res_addr_even  in  ADDR_W  destination register.
- res_data_even  in  DATA_W  result value, final at issue.
- res_lat_even  in  LAT_W  cycles until writeback (1..DEPTH).
- res_valid_odd, res_addr_odd, res_data_odd, res_lat_odd  in  as even  odd-pipe equivalents.
- rt_addr_even  out  ADDR_W  RF write address, even port.
- rt_even  out  DATA_W  RF write data, even port.
- reg_write_even  out  1  RF write enable, even port.
- rt_addr_odd, rt_odd, reg_write_odd  out  as even  odd port.
- q_addr_a, q_addr_b, q_addr_c  in  ADDR_W  forwarding query addresses.
- fwd_hit_a/b/c  out  1  matching in-flight result exists.
- fwd_data_a/b/c  out  DATA_W  forwarded value; 0 when no hit.
- slot_conflict_even, slot_conflict_odd  out  1  structural-hazard flag, one cycle.
- waw_drop  out  1  same-cycle same-address write, even write suppressed.

Behaviour:
- Reset (sync, active-high): all slots invalid; all rt_*, reg_write_*, slot_conflict_*, waw_drop = 0. Reset overrides flush and issue in the same cycle.
- Slots: per pipe, slot[0..DEPTH-1], each holding {valid, addr, data}.
- Each edge, per pipe: slot[k] <= slot[k+1]; slot[DEPTH-1] <= invalid; output regs <= slot[0].
- Issue: if res_valid is high at edge E, the entry is written into slot[L-1] after the shift, where L = res_lat.
  - L=0 is treated as 1; L>DEPTH is clamped to DEPTH.
  - reg_write is high for exactly the one cycle following edge E+L, with rt_addr/rt equal to the issued values.
  - Latency 1 therefore writes the cycle after the next edge.
- Outputs are registered. When reg_write=0, rt_addr and rt hold 0.
- Structural conflict: the target slot is already valid after the shift (an older entry lands there).
  - The new entry overwrites it.
  - slot_conflict_<pipe> is high for the cycle after E.
- Cross-pipe WAW at the output stage: slot[0] of both pipes valid with equal addr.
  - Odd wins: reg_write_odd=1, reg_write_even=0.
  - waw_drop=1 in that same cycle.
  - Different addresses: both write.
- Flush at edge E:
  - All slots are invalidated.
  - Output regs load invalid, so reg_write_* is 0 the next cycle.
  - A res_valid in the same cycle is dropped.
  - A write already on the outputs during the flush cycle still completes.
- Forwarding is combinational over all valid slots of both pipes plus both output registers. Match is addr == q_addr.
  - Priority 1: entry with the highest slot index (latest writeback).
  - Priority 2: slots over output registers.
  - Tie-break: odd over even.
  - Address 0 is not special.
- No backpressure: the RF always accepts writes.

Test Plan:
- Single even result, addr 5, data 128'h000A..0, lat 2, issued at edge E → reg_write_even=1, rt_addr_even=5, rt_even=000A..0 only in the cycle after E+2; no other write pulses.
- Parallel issue: even addr 5 lat 3 and odd addr 5 lat 3 in the same cycle → in the writeback cycle reg_write_odd=1, rt_odd=odd data, reg_write_even=0, waw_drop=1. Repeat with even addr 6 → both write, waw_drop=0.
- Slot conflict: even addr 3 lat 4 at E, then even addr 9 lat 3 at E+1 (both target the same slot) → slot_conflict_even=1 the cycle after E+1; only addr 9 written, at cycle after E+4.
- Forwarding: odd addr 7 data 000B..0 lat 5 in flight; query q_addr_a=7 on each following cycle → fwd_hit_a=1, fwd_data_a=000B..0 through the writeback cycle, then 0/0. Also in flight, even addr 7 data 000C..0 with later writeback → data 000C..0 wins.
- Flush mid-flight: three results with lat 2, 5, 7, flush two edges after issue → only results already on the outputs write; no reg_write afterwards; fwd_hit_* = 0.
- Reset mid-operation: reset asserted with slots full → next cycle all outputs 0; no stale writes after deassert; a fresh lat-1 issue then writes correctly.
